// File: rtl/key_game_pkg.sv
// Shared types for the key game controller.
//   game_state_t  : sequencer states
//   MODE_COLLECT  : checker compares against the collectable code set
//   MODE_FINAL    : checker compares against the final code
package key_game_pkg;

  typedef enum logic [2:0] {
    PLAY,
    ARM,
    EVAL,
    WIN,
    LOSE
  } game_state_t;

  localparam logic MODE_COLLECT = 1'b0;
  localparam logic MODE_FINAL   = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Button front end: invert, two-stage synchroniser, stability timer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   key_n          : raw active-low button
//   pressed_pulse  : one cycle when the debounced level goes released->pressed
module btn_debounce
  import key_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Down-counter runs only while the synchronised sample disagrees with the
  // accepted level; the DEBOUNCE_CYCLES-th consecutive disagreeing sample
  // (terminal count) flips the level. Any agreeing sample reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      level_q       <= 1'b0;
      cnt_q         <= RELOAD;
      pressed_pulse <= 1'b0;
    end else begin
      sync_q1       <= ~key_n;
      sync_q2       <= sync_q1;
      pressed_pulse <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= RELOAD;
      end else if (cnt_q == '0) begin
        level_q       <= sync_q2;
        cnt_q         <= RELOAD;
        pressed_pulse <= sync_q2;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_game_ctrl.sv
// Sequencer for the switch-code checker: snapshots the switches on a submit
// press, waits out the checker's registered latency, then scores the result.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   sw                          : raw board switches
//   key_submit_n, key_start_n   : raw active-low buttons
//   chk_match, chk_final_match  : checker results (1-cycle registered)
//   chk_sw, chk_mode            : value and mode presented to the checker
//   score, lives                : accepted codes / lives remaining
//   hit_pulse, miss_pulse       : one-cycle submission outcome
//   won, lost                   : terminal levels
//
// state | meaning
// PLAY  | idle, waiting for a submit press
// ARM   | chk_sw snapshot stable, checker registering it
// EVAL  | checker result valid, score or charge a life
// WIN   | final code accepted, terminal
// LOSE  | lives exhausted, terminal
module key_game_ctrl
  import key_game_pkg::*;
#(
  parameter int SW_W            = 10,
  parameter int CODES_NEEDED    = 3,
  parameter int LIVES           = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SW_W-1:0] sw,
  input  logic            key_submit_n,
  input  logic            key_start_n,
  input  logic            chk_match,
  input  logic            chk_final_match,
  output logic [SW_W-1:0] chk_sw,
  output logic            chk_mode,
  output logic [3:0]      score,
  output logic [2:0]      lives,
  output logic            hit_pulse,
  output logic            miss_pulse,
  output logic            won,
  output logic            lost
);

  localparam logic [3:0] SCORE_MAX  = 4'(CODES_NEEDED);
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  logic            submit_pulse;
  logic            start_pulse;
  game_state_t     state_q;
  logic [SW_W-1:0] last_code_q;
  logic            last_valid_q;
  logic [3:0]      score_inc;
  logic [2:0]      lives_dec;
  logic            new_code;
  logic            eval_pass;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_submit_n),
    .pressed_pulse(submit_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_start_n),
    .pressed_pulse(start_pulse)
  );

  assign score_inc = (score < SCORE_MAX) ? score + 4'd1 : score;
  assign lives_dec = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
  assign new_code  = !last_valid_q || (chk_sw != last_code_q);
  assign eval_pass = (chk_mode == MODE_FINAL) ? chk_final_match : chk_match;

  // Start is folded into the reset branch so it overrides any in-flight
  // evaluation; the debouncers are deliberately left running.
  always_ff @(posedge clk) begin
    if (reset || start_pulse) begin
      state_q      <= PLAY;
      chk_sw       <= '0;
      chk_mode     <= MODE_COLLECT;
      score        <= '0;
      lives        <= LIVES_INIT;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      won          <= 1'b0;
      lost         <= 1'b0;
      last_code_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state_q)
        PLAY: begin
          if (submit_pulse) begin
            chk_sw  <= sw;
            state_q <= ARM;
          end
        end
        ARM: state_q <= EVAL;
        EVAL: begin
          if (eval_pass) begin
            if (chk_mode == MODE_FINAL) begin
              won       <= 1'b1;
              hit_pulse <= 1'b1;
              state_q   <= WIN;
            end else begin
              state_q <= PLAY;
              // A repeat of the last accepted code is silently ignored.
              if (new_code) begin
                score        <= score_inc;
                last_code_q  <= chk_sw;
                last_valid_q <= 1'b1;
                hit_pulse    <= 1'b1;
                if (score_inc == SCORE_MAX) chk_mode <= MODE_FINAL;
              end
            end
          end else begin
            lives      <= lives_dec;
            miss_pulse <= 1'b1;
            if (lives_dec == 3'd0) begin
              lost    <= 1'b1;
              state_q <= LOSE;
            end else begin
              state_q <= PLAY;
            end
          end
        end
        WIN, LOSE: state_q <= state_q;
        default:   state_q <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_key_game_ctrl.sv
// Self-checking bench for key_game_ctrl with a behavioural checker and a
// rule-level game model. A second instance with a 1-cycle debounce lets a
// submit pulse land inside an evaluation.
module tb_key_game_ctrl;

  localparam int DB      = 4;
  localparam int CODES   = 3;
  localparam int NLIVES  = 3;
  localparam int HOLD    = 6;
  localparam int WIN_LEN = 20;
  localparam int CAP_C   = DB + 2;   // window cycle where chk_sw shows the snapshot
  localparam int LAT     = DB + 4;   // window cycle where hit/miss shows
  localparam logic [9:0] FINAL_CODE = 10'b1101001100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sw = '0;
  logic       key_submit_n = 1'b1;
  logic       key_start_n = 1'b1;
  logic       chk_match = 1'b0;
  logic       chk_final_match = 1'b0;
  logic [9:0] chk_sw;
  logic       chk_mode;
  logic [3:0] score;
  logic [2:0] lives;
  logic       hit_pulse, miss_pulse, won, lost;

  logic [9:0] f_sw = '0;
  logic       f_key_submit_n = 1'b1;
  logic       f_chk_match = 1'b0;
  logic       f_chk_final_match = 1'b0;
  logic [9:0] f_chk_sw;
  logic       f_chk_mode;
  logic [3:0] f_score;
  logic [2:0] f_lives;
  logic       f_hit_pulse, f_miss_pulse, f_won, f_lost;

  int n_checks = 0;
  int n_errors = 0;

  int         m_score, m_lives;
  logic [9:0] m_last, m_sw;
  bit         m_lv, m_mode, m_won, m_lost;

  always #5 clk = ~clk;

  key_game_ctrl #(.SW_W(10), .CODES_NEEDED(CODES), .LIVES(NLIVES), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key_submit_n(key_submit_n), .key_start_n(key_start_n),
    .chk_match(chk_match), .chk_final_match(chk_final_match), .chk_sw(chk_sw), .chk_mode(chk_mode),
    .score(score), .lives(lives), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .won(won), .lost(lost)
  );

  key_game_ctrl #(.SW_W(10), .CODES_NEEDED(CODES), .LIVES(NLIVES), .DEBOUNCE_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .sw(f_sw), .key_submit_n(f_key_submit_n), .key_start_n(1'b1),
    .chk_match(f_chk_match), .chk_final_match(f_chk_final_match), .chk_sw(f_chk_sw), .chk_mode(f_chk_mode),
    .score(f_score), .lives(f_lives), .hit_pulse(f_hit_pulse), .miss_pulse(f_miss_pulse), .won(f_won), .lost(f_lost)
  );

  function automatic bit is_valid(input logic [9:0] c);
    case (c)
      10'h3FF, 10'h155, 10'h2AA, 10'h0F0, 10'h00F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural checker: registered compare, one cycle of latency.
  always @(posedge clk) begin
    chk_match         <= is_valid(chk_sw);
    chk_final_match   <= (chk_sw == FINAL_CODE);
    f_chk_match       <= is_valid(f_chk_sw);
    f_chk_final_match <= (f_chk_sw == FINAL_CODE);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_lives = NLIVES; m_last = '0; m_sw = '0;
    m_lv = 0; m_mode = 0; m_won = 0; m_lost = 0;
  endtask

  // Game rules applied to one accepted submit press.
  task automatic model_submit(input logic [9:0] code, output bit eh, output bit em);
    eh = 0; em = 0;
    if (m_won || m_lost) return;
    m_sw = code;
    if (m_mode) begin
      if (code == FINAL_CODE) begin eh = 1; m_won = 1; end
      else em = 1;
    end else if (is_valid(code)) begin
      if (!m_lv || code != m_last) begin
        eh = 1;
        if (m_score < CODES) m_score++;
        m_last = code; m_lv = 1;
        if (m_score == CODES) m_mode = 1;
      end
    end else begin
      em = 1;
    end
    if (em) begin
      if (m_lives > 0) m_lives--;
      if (m_lives == 0) m_lost = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_score"}, 32'(score), 32'(m_score));
    chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
    chk({tag, "_mode"}, 32'(chk_mode), 32'(m_mode));
    chk({tag, "_won"}, 32'(won), 32'(m_won));
    chk({tag, "_lost"}, 32'(lost), 32'(m_lost));
    chk({tag, "_chk_sw"}, 32'(chk_sw), 32'(m_sw));
  endtask

  // Fixed-length window: buttons held low from *_at for hold cycles
  // (negative *_at = untouched); outcome pulses counted each cycle.
  task automatic run_win(input int sub_at, input int st_at, input int hold, input logic [9:0] code,
                         output int hits, output int misses, output int fh, output int fm,
                         output logic [9:0] cap);
    hits = 0; misses = 0; fh = -1; fm = -1; cap = '0;
    sw = code;
    for (int c = 0; c < WIN_LEN; c++) begin
      @(negedge clk);
      key_submit_n = !(sub_at >= 0 && c >= sub_at && c < sub_at + hold);
      key_start_n  = !(st_at >= 0 && c >= st_at && c < st_at + hold);
      @(posedge clk); #1;
      if (hit_pulse)  begin hits++;   if (fh < 0) fh = c; end
      if (miss_pulse) begin misses++; if (fm < 0) fm = c; end
      if (c == CAP_C) cap = chk_sw;
    end
  endtask

  task automatic do_submit(input string tag, input logic [9:0] code);
    bit eh, em;
    int hits, misses, fh, fm;
    logic [9:0] cap;
    model_submit(code, eh, em);
    run_win(0, -1, HOLD, code, hits, misses, fh, fm, cap);
    chk({tag, "_hits"}, 32'(hits), 32'(eh));
    chk({tag, "_misses"}, 32'(misses), 32'(em));
    if (eh) chk({tag, "_hit_lat"}, 32'(fh), 32'(LAT));
    if (em) chk({tag, "_miss_lat"}, 32'(fm), 32'(LAT));
    chk({tag, "_cap_sw"}, 32'(cap), 32'(m_sw));
    check_state(tag);
  endtask

  task automatic do_start(input string tag);
    int hits, misses, fh, fm;
    logic [9:0] cap;
    run_win(-1, 0, HOLD, sw, hits, misses, fh, fm, cap);
    model_reset();
    chk({tag, "_pulses"}, 32'(hits + misses), 32'd0);
    check_state(tag);
  endtask

  initial begin
    int hits, misses, fh, fm, f_hits;
    logic [9:0] cap, code;
    model_reset();
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check_state("reset");
    chk("reset_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);

    // Short press must not register.
    run_win(0, -1, 3, 10'h3FF, hits, misses, fh, fm, cap);
    chk("short_pulses", 32'(hits + misses), 32'd0);
    check_state("short");

    do_submit("first", 10'h3FF);
    do_submit("repeat", 10'h3FF);
    do_submit("invalid", 10'h000);
    do_submit("second", 10'h155);
    do_submit("third", 10'h2AA);
    do_submit("final", FINAL_CODE);
    do_submit("after_win", FINAL_CODE);
    do_start("restart1");

    do_submit("bad1", 10'h000);
    do_submit("bad2", 10'h123);
    do_submit("bad3", 10'h000);
    do_submit("after_lose", 10'h3FF);
    do_start("restart2");

    // Start pulse lands in the EVAL cycle of a valid submission.
    do_submit("pre_ovl", 10'h3FF);
    run_win(0, 2, HOLD, 10'h155, hits, misses, fh, fm, cap);
    model_reset();
    chk("ovl_pulses", 32'(hits + misses), 32'd0);
    check_state("ovl");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_start("rnd_start");
      end else begin
        case ($urandom_range(0, 9))
          0: code = 10'h3FF;
          1: code = 10'h155;
          2: code = 10'h2AA;
          3: code = 10'h0F0;
          4: code = 10'h00F;
          5, 6: code = FINAL_CODE;
          default: code = 10'($urandom);
        endcase
        do_submit("rnd", code);
      end
    end

    // Second pulse on the fast instance arrives while it is in EVAL and
    // carries a different valid code; it must be dropped.
    f_hits = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      f_key_submit_n = !(c == 0 || c == 2);
      f_sw = (c >= 4) ? 10'h155 : 10'h3FF;
      @(posedge clk); #1;
      if (f_hit_pulse) f_hits++;
    end
    chk("drop_hits", 32'(f_hits), 32'd1);
    chk("drop_score", 32'(f_score), 32'd1);
    chk("drop_chk_sw", 32'(f_chk_sw), 32'h3FF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
